cmd_frame_rx: RTL and testbench

//  Host-to-FPGA command receiver; inverse of the trace/ciphertext UART upload path.

---
 rtl/cmd_frame_rx.sv | 185 ++++++++++++++++++
 tb/tb_cmd_frame_rx.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_frame_rx.sv
// Framed command receiver: SYNC, CMD, LEN, payload, XOR checksum.
// Commits delay/key/plaintext registers and issues a one-cycle start request.
module cmd_frame_rx #(
    parameter int N              = 16,
    parameter int M              = 4,
    parameter int BLOCK_SIZE     = 2 * N,
    parameter int KEY_SIZE       = N * M,
    parameter int TIMEOUT_CYCLES = 2 ** 20,
    parameter logic [KEY_SIZE-1:0] DEFAULT_KEY   = 64'h1918111009080100,
    parameter logic [7:0]          DEFAULT_DELAY = 8'd15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_dv,
    input  logic [7:0]            rx_byte,
    input  logic                  busy_i,
    output logic [7:0]            delay_o,
    output logic [KEY_SIZE-1:0]   key_o,
    output logic [BLOCK_SIZE-1:0] pt_o,
    output logic                  start_o,
    output logic                  err_o,
    output logic [1:0]            err_code,
    output logic [7:0]            frame_cnt
);

    localparam int SHADOW_W = (KEY_SIZE > BLOCK_SIZE) ? KEY_SIZE : BLOCK_SIZE;
    localparam int TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] CMD_DELAY = 8'h01;
    localparam logic [7:0] CMD_KEY   = 8'h02;
    localparam logic [7:0] CMD_PT    = 8'h03;
    localparam logic [7:0] CMD_RUN   = 8'h04;
    localparam logic [7:0] LEN_KEY   = 8'(KEY_SIZE / 8);
    localparam logic [7:0] LEN_PT    = 8'(BLOCK_SIZE / 8);

    localparam logic [1:0] ERR_CSUM = 2'd0;
    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_TMO  = 2'd2;
    localparam logic [1:0] ERR_BUSY = 2'd3;

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_LEN, S_PAYLOAD, S_CSUM} state_t;

    state_t                  r_state, w_state_nxt;
    logic [7:0]              r_cmd, r_len, r_cnt, r_csum;
    logic [SHADOW_W-1:0]     r_shadow;
    logic [TMO_W-1:0]        r_tmo_cnt;
    logic [7:0]              r_delay, r_frame_cnt;
    logic [KEY_SIZE-1:0]     r_key;
    logic [BLOCK_SIZE-1:0]   r_pt;
    logic                    r_start, r_err;
    logic [1:0]              r_err_code;

    logic                    w_timeout, w_len_ok, w_err, w_commit;
    logic [1:0]              w_err_code;

    // A byte arriving on the expiry cycle takes priority over the timeout.
    assign w_timeout = (r_state != S_IDLE) && !rx_dv && (r_tmo_cnt == TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_err       = 1'b0;
        w_err_code  = ERR_CSUM;
        w_commit    = 1'b0;
        case (r_cmd)
            CMD_DELAY: w_len_ok = (rx_byte == 8'd1);
            CMD_KEY:   w_len_ok = (rx_byte == LEN_KEY);
            CMD_PT:    w_len_ok = (rx_byte == LEN_PT);
            CMD_RUN:   w_len_ok = (rx_byte == 8'd0);
            default:   w_len_ok = 1'b0;
        endcase

        case (r_state)
            S_IDLE:    if (rx_dv && rx_byte == SYNC_BYTE) w_state_nxt = S_CMD;
            S_CMD:     if (rx_dv) w_state_nxt = S_LEN;
            S_LEN: begin
                if (rx_dv) begin
                    if (!w_len_ok) begin
                        w_err       = 1'b1;
                        w_err_code  = ERR_LEN;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = (rx_byte == 8'd0) ? S_CSUM : S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: if (rx_dv && r_cnt == r_len - 8'd1) w_state_nxt = S_CSUM;
            S_CSUM: begin
                if (rx_dv) begin
                    w_state_nxt = S_IDLE;
                    if (rx_byte != r_csum) begin
                        w_err      = 1'b1;
                        w_err_code = ERR_CSUM;
                    end else if (r_cmd == CMD_RUN && busy_i) begin
                        w_err      = 1'b1;
                        w_err_code = ERR_BUSY;
                    end else begin
                        w_commit   = 1'b1;
                    end
                end
            end
            default:   w_state_nxt = S_IDLE;
        endcase

        if (w_timeout) begin
            w_err       = 1'b1;
            w_err_code  = ERR_TMO;
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd       <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_csum      <= '0;
            r_tmo_cnt   <= '0;
            r_delay     <= DEFAULT_DELAY;
            r_key       <= DEFAULT_KEY;
            r_pt        <= '0;
            r_start     <= 1'b0;
            r_err       <= 1'b0;
            r_err_code  <= ERR_CSUM;
            r_frame_cnt <= '0;
        end else begin
            r_err   <= w_err;
            r_start <= w_commit && (r_cmd == CMD_RUN);
            if (w_err) r_err_code <= w_err_code;

            if (r_state == S_IDLE || rx_dv) r_tmo_cnt <= '0;
            else                            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);

            if (rx_dv) begin
                case (r_state)
                    S_CMD: begin
                        r_cmd  <= rx_byte;
                        r_csum <= rx_byte;
                    end
                    S_LEN: begin
                        r_len  <= rx_byte;
                        r_csum <= r_csum ^ rx_byte;
                        r_cnt  <= '0;
                    end
                    S_PAYLOAD: begin
                        r_csum <= r_csum ^ rx_byte;
                        r_cnt  <= r_cnt + 8'd1;
                    end
                    default: ;
                endcase
            end

            if (w_commit) begin
                case (r_cmd)
                    CMD_DELAY: r_delay <= r_shadow[7:0];
                    CMD_KEY:   r_key   <= r_shadow[KEY_SIZE-1:0];
                    CMD_PT:    r_pt    <= r_shadow[BLOCK_SIZE-1:0];
                    default: ;
                endcase
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

    // NOTE: the shadow needs no reset; only bytes of the current frame are ever committed.
    always_ff @(posedge clk) begin
        if (rx_dv && r_state == S_PAYLOAD) r_shadow <= {r_shadow[SHADOW_W-9:0], rx_byte};
    end

    assign delay_o   = r_delay;
    assign key_o     = r_key;
    assign pt_o      = r_pt;
    assign start_o   = r_start;
    assign err_o     = r_err;
    assign err_code  = r_err_code;
    assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_cmd_frame_rx.sv
// Bench for cmd_frame_rx: table of frames plus hand sequences, checked by a
// scoreboard of expected events popped whenever the DUT reports a frame result.
module tb_cmd_frame_rx;

    localparam int TMO = 64;
    localparam logic [63:0] DEF_KEY = 64'h1918111009080100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_dv = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic        busy_i = 1'b0;
    logic [7:0]  delay_o;
    logic [63:0] key_o;
    logic [31:0] pt_o;
    logic        start_o, err_o;
    logic [1:0]  err_code;
    logic [7:0]  frame_cnt;

    cmd_frame_rx #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .rx_dv(rx_dv), .rx_byte(rx_byte), .busy_i(busy_i),
        .delay_o(delay_o), .key_o(key_o), .pt_o(pt_o), .start_o(start_o),
        .err_o(err_o), .err_code(err_code), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  cmd;
        logic [7:0]  len;
        logic [63:0] payload;
        bit          bad_csum;
        bit          busy;
        bit          exp_err;
        logic [1:0]  exp_code;
    } vec_t;

    typedef struct {
        bit          is_err;
        bit          start;
        logic [1:0]  code;
        logic [7:0]  delay;
        logic [63:0] key;
        logic [31:0] pt;
        logic [7:0]  cnt;
    } exp_t;

    int   total = 0;
    int   bad = 0;
    exp_t sb[$];

    logic [7:0]  m_delay = 8'h0F;
    logic [63:0] m_key = DEF_KEY;
    logic [31:0] m_pt = '0;
    logic [7:0]  m_cnt = '0;
    logic [1:0]  m_code = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_delay = 8'h0F; m_key = DEF_KEY; m_pt = '0; m_cnt = '0; m_code = '0;
    endtask

    task automatic push_ok(input logic [7:0] cmd, input logic [63:0] payload);
        exp_t e;
        case (cmd)
            8'h01:   m_delay = payload[7:0];
            8'h02:   m_key = payload;
            8'h03:   m_pt = payload[31:0];
            default: ;
        endcase
        m_cnt = m_cnt + 8'd1;
        e = '{is_err: 1'b0, start: (cmd == 8'h04), code: m_code, delay: m_delay,
              key: m_key, pt: m_pt, cnt: m_cnt};
        sb.push_back(e);
    endtask

    task automatic push_err(input logic [1:0] code);
        exp_t e;
        m_code = code;
        e = '{is_err: 1'b1, start: 1'b0, code: m_code, delay: m_delay,
              key: m_key, pt: m_pt, cnt: m_cnt};
        sb.push_back(e);
    endtask

    // Tasks start and end 1 time unit after a rising edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_dv = 1'b1;
        rx_byte = b;
        @(posedge clk); #1;
        rx_dv = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic drain(input string name, input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) begin @(posedge clk); #1; end
        check(name, sb.size(), 0);
    endtask

    task automatic run_vec(input vec_t v, input int gap, input bit do_drain);
        logic [7:0] cs, b;
        busy_i = v.busy;
        send_byte(8'hA5, gap);
        send_byte(v.cmd, gap);
        if (v.exp_err && v.exp_code == 2'd1) begin
            push_err(2'd1);
            send_byte(v.len, gap);
        end else begin
            send_byte(v.len, gap);
            cs = v.cmd ^ v.len;
            for (int i = 0; i < int'(v.len); i++) begin
                b = v.payload[(int'(v.len) - 1 - i) * 8 +: 8];
                cs = cs ^ b;
                send_byte(b, gap);
            end
            if (v.exp_err) push_err(v.exp_code);
            else           push_ok(v.cmd, v.payload);
            send_byte(v.bad_csum ? ~cs : cs, gap);
        end
        if (do_drain) begin
            drain("frame_result", 20);
            busy_i = 1'b0;
        end
    endtask

    // Every accepted frame bumps frame_cnt; every rejected one pulses err_o.
    logic [7:0] prev_cnt = '0;
    bit         prev_err = 1'b0, prev_start = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_cnt = frame_cnt; prev_err = 1'b0; prev_start = 1'b0;
        end else begin
            if (err_o || start_o || frame_cnt != prev_cnt) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_event: err_o=%0b start_o=%0b frame_cnt=%0d none expected",
                             err_o, start_o, frame_cnt);
                end else begin
                    e = sb.pop_front();
                    check("ev_is_err", err_o, e.is_err);
                    check("ev_start", start_o, e.start);
                    check("ev_err_code", err_code, e.code);
                    check("ev_delay", delay_o, e.delay);
                    check("ev_key", key_o, e.key);
                    check("ev_pt", pt_o, e.pt);
                    check("ev_frame_cnt", frame_cnt, e.cnt);
                end
                if (err_o)   check("err_one_cycle", prev_err, 1'b0);
                if (start_o) check("start_one_cycle", prev_start, 1'b0);
            end
            prev_cnt = frame_cnt; prev_err = err_o; prev_start = start_o;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{8'h01, 8'd1, 64'h20,               1'b0, 1'b0, 1'b0, 2'd0};
        vecs[1]  = '{8'h02, 8'd8, 64'h0001020304050607, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[2]  = '{8'h03, 8'd4, 64'hDEADBEEF,         1'b0, 1'b0, 1'b0, 2'd0};
        vecs[3]  = '{8'h01, 8'd1, 64'h21,               1'b1, 1'b0, 1'b1, 2'd0};
        vecs[4]  = '{8'h03, 8'd2, 64'h0,                1'b0, 1'b0, 1'b1, 2'd1};
        vecs[5]  = '{8'h01, 8'd1, 64'hA5,               1'b0, 1'b0, 1'b0, 2'd0};
        vecs[6]  = '{8'h04, 8'd0, 64'h0,                1'b0, 1'b0, 1'b0, 2'd0};
        vecs[7]  = '{8'h04, 8'd0, 64'h0,                1'b0, 1'b1, 1'b1, 2'd3};
        vecs[8]  = '{8'h07, 8'd1, 64'h0,                1'b0, 1'b0, 1'b1, 2'd1};
        vecs[9]  = '{8'h02, 8'd8, 64'hA5A50102_0304A5FF, 1'b0, 1'b0, 1'b0, 2'd0};
        vecs[10] = '{8'h04, 8'd0, 64'h0,                1'b1, 1'b1, 1'b1, 2'd0};
        vecs[11] = '{8'h03, 8'd4, 64'h12345678,         1'b0, 1'b0, 1'b0, 2'd0};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_delay", delay_o, 8'h0F);
        check("rst_key", key_o, DEF_KEY);
        check("rst_pt", pt_o, 32'h0);
        check("rst_start", start_o, 1'b0);
        check("rst_err", err_o, 1'b0);
        check("rst_err_code", err_code, 2'd0);
        check("rst_frame_cnt", frame_cnt, 8'd0);

        // Bytes outside a frame are ignored.
        send_byte(8'h00, 1); send_byte(8'hFF, 0); send_byte(8'h04, 2);

        foreach (vecs[i]) run_vec(vecs[i], 1, 1'b1);

        // Back-to-back frames with no idle cycles at all.
        run_vec(vecs[0], 0, 1'b0);
        run_vec(vecs[6], 0, 1'b0);
        run_vec(vecs[2], 0, 1'b1);

        // Slow frame: gaps just under the timeout still complete.
        run_vec(vecs[11], TMO - 2, 1'b1);
        run_vec(vecs[3], 0, 1'b1);

        // Timeout after A5 02, then a normal frame is accepted.
        push_err(2'd2);
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        repeat (TMO / 2) @(posedge clk);
        #1 check("tmo_not_early", sb.size(), 1);
        drain("tmo_fired", TMO + 8);
        run_vec(vecs[5], 1, 1'b1);

        // Reset in the middle of a key payload.
        send_byte(8'hA5, 0); send_byte(8'h02, 0); send_byte(8'h08, 0);
        send_byte(8'h00, 0); send_byte(8'h01, 0); send_byte(8'h02, 0);
        rst = 1'b1;
        @(posedge clk); #1; @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        check("midrst_delay", delay_o, 8'h0F);
        check("midrst_key", key_o, DEF_KEY);
        check("midrst_pt", pt_o, 32'h0);
        check("midrst_err_code", err_code, 2'd0);
        check("midrst_frame_cnt", frame_cnt, 8'd0);
        check("midrst_strobes", {start_o, err_o}, 2'b00);

        // Bad checksum right after reset leaves the default delay.
        run_vec(vecs[3], 1, 1'b1);
        run_vec(vecs[1], 1, 1'b1);

        repeat (5) @(posedge clk);
        #1 check("sb_empty_end", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
